// File: rtl/vend_pkg.sv
// Shared vending definitions: coin one-hot encodings, coin values and the
// dispenser state encoding. The coin-accepting front end imports this too,
// so both sides agree on what each coin bit means.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_PRESENT = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // One-hot coin encodings as seen on the coin mechanism bus
    localparam logic [3:0] COIN_NONE = 4'b0000;
    localparam logic [3:0] COIN_1    = 4'b0001;
    localparam logic [3:0] COIN_5    = 4'b0010;
    localparam logic [3:0] COIN_10   = 4'b0100;
    localparam logic [3:0] COIN_25   = 4'b1000;

    // Coin values in cents, sized to the 7-bit amount datapath
    localparam logic [6:0] VAL_1  = 7'd1;
    localparam logic [6:0] VAL_5  = 7'd5;
    localparam logic [6:0] VAL_10 = 7'd10;
    localparam logic [6:0] VAL_25 = 7'd25;

    // Cent value of a one-hot coin; anything not a single known coin is worth 0
    function automatic logic [6:0] coin_value(input logic [3:0] coin);
        logic [6:0] v;
        v = 7'd0;
        case (coin)
            COIN_25: v = VAL_25;
            COIN_10: v = VAL_10;
            COIN_5:  v = VAL_5;
            COIN_1:  v = VAL_1;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin whose value does not exceed the amount
// still owed. Purely combinational; the dispenser registers the result.
module coin_select
    import vend_pkg::*;
(
    input  logic [6:0] remaining,
    output logic [3:0] coin,
    output logic [6:0] value
);

    // Pick the biggest coin that fits; nothing when nothing is owed
    always_comb begin
        coin = COIN_NONE;
        if (remaining >= VAL_25) begin
            coin = COIN_25;
        end else if (remaining >= VAL_10) begin
            coin = COIN_10;
        end else if (remaining >= VAL_5) begin
            coin = COIN_5;
        end else if (remaining >= VAL_1) begin
            coin = COIN_1;
        end
        value = coin_value(coin);
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a refund amount, then presents coins one at a
// time (greedy 25/10/5/1) to the coin mechanism, waiting for each to be
// acknowledged and leaving an idle gap between coins.
// remaining is plain binary (0..MAX_AMOUNT) so it can feed the two-digit
// display driver without further conversion.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int MAX_AMOUNT = 99,  // largest refundable amount, at most 127
    parameter int GAP_CYCLES = 2    // gap counter load, 1..15
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [3:0] coin_type,
    output logic [6:0] remaining,
    output logic [3:0] coin_count,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // One extra bit so amounts up to 127 compare cleanly against the limit
    localparam logic [7:0] MAX_AMT  = 8'(MAX_AMOUNT);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    state_t     state_q, state_d;
    logic [6:0] remaining_q, remaining_d;
    logic [3:0] count_q, count_d;
    logic [3:0] coin_q, coin_d;
    logic [3:0] gap_q, gap_d;
    logic       err_q, err_d;

    logic [3:0] sel_coin;
    logic [6:0] sel_value;

    coin_select u_coin_select (
        .remaining (remaining_q),
        .coin      (sel_coin),
        .value     (sel_value)
    );

    // State and datapath registers; reset wins over every other input
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 7'd0;
            count_q     <= 4'd0;
            coin_q      <= COIN_NONE;
            gap_q       <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            coin_q      <= coin_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        coin_d      = coin_q;
        gap_d       = gap_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, amount} > MAX_AMT) begin
                        // Rejected: flag it and keep the previous totals on show
                        err_d = 1'b1;
                    end else begin
                        remaining_d = amount;
                        count_d     = 4'd0;
                        err_d       = 1'b0;
                        state_d     = ST_SELECT;
                    end
                end
            end

            ST_SELECT: begin
                if (remaining_q == 7'd0) begin
                    state_d = ST_DONE;
                end else begin
                    coin_d  = sel_coin;
                    state_d = ST_PRESENT;
                end
            end

            ST_PRESENT: begin
                // remaining_q has not moved since SELECT, so sel_value is the
                // value of the coin being presented and never exceeds it
                if (coin_ack) begin
                    remaining_d = remaining_q - sel_value;
                    count_d     = count_q + 4'd1;
                    coin_d      = COIN_NONE;
                    if (remaining_q == sel_value) begin
                        state_d = ST_DONE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                // <= also covers a zero load so the gap can never stall
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        coin_valid = (state_q == ST_PRESENT);
        coin_type  = coin_q;
        remaining  = remaining_q;
        coin_count = count_q;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with default parameters
// (MAX_AMOUNT=99, GAP_CYCLES=2).
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] amount;
    logic       coin_ack;
    logic       coin_valid;
    logic [3:0] coin_type;
    logic [6:0] remaining;
    logic [3:0] coin_count;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;

    // Observations from the last transaction run
    logic [3:0] got[$];
    int         holds[$];
    int         gaps[$];
    int         dones;
    int         done_cyc;
    int         first_cyc;

    logic [3:0] exp99 [9] = '{4'h8, 4'h8, 4'h8, 4'h4, 4'h4, 4'h1, 4'h1, 4'h1, 4'h1};

    change_dispenser dut (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .start         (start),
        .amount        (amount),
        .coin_ack      (coin_ack),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .remaining     (remaining),
        .coin_count    (coin_count),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a transaction at the next edge (N) and follow it to completion.
    // tie: coin_ack held at 1 throughout; otherwise ack after dly cycles of
    // presentation. inj: cycle index at which a start with amount=10 is pulsed.
    task automatic run(input logic [6:0] amt, input bit tie, input int dly, input int inj);
        int  c, h, idle;
        bit  prev, fin;
        got.delete(); holds.delete(); gaps.delete();
        dones = 0; done_cyc = -1; first_cyc = -1;
        coin_ack = tie;
        start = 1'b1; amount = amt;
        tick();
        start = 1'b0;
        c = 1; h = 0; idle = 0; prev = 1'b0; fin = 1'b0;
        while (!fin && c < 400) begin
            if (coin_valid) begin
                if (!prev) begin
                    got.push_back(coin_type);
                    if (first_cyc < 0) first_cyc = c;
                    if (got.size() > 1) gaps.push_back(idle);
                    h = 0;
                end else begin
                    chk("coin_stable", coin_type, got[$]);
                end
                h++;
                idle = 0;
            end else begin
                if (prev) holds.push_back(h);
                idle++;
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
            if (dones > 0 && !done && !busy) fin = 1'b1;
            prev = coin_valid;
            if (!tie) coin_ack = coin_valid && (h == dly);
            start = (c == inj);
            if (c == inj) amount = 7'd10;
            if (!fin) begin
                tick();
                c++;
            end
        end
        coin_ack = 1'b0;
        start = 1'b0;
        chk("run_finished", fin, 1);
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_valid"},  coin_valid, 0);
        chk({tag, "_type"},   coin_type, 0);
        chk({tag, "_rem"},    remaining, 0);
        chk({tag, "_count"},  coin_count, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_err"},    err, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; amount = 7'd0; coin_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_idle_reset("reset");

        // 99 cents, ack tied high: greedy sequence, 3 idle cycles (2 gap + select)
        run(7'd99, 1'b1, 0, -1);
        chk("c99_ncoins", got.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < got.size()) chk($sformatf("c99_coin%0d", i), got[i], exp99[i]);
        chk("c99_first_cyc", first_cyc, 2);
        chk("c99_gap", gaps.size() > 0 ? gaps[0] : -1, 3);
        chk("c99_dones", dones, 1);
        chk("c99_count", coin_count, 9);
        chk("c99_rem", remaining, 0);

        // Over the limit: rejected, nothing moves, totals held
        start = 1'b1; amount = 7'd100;
        tick();
        start = 1'b0;
        chk("rej100_err", err, 1);
        chk("rej100_busy", busy, 0);
        tick();
        chk("rej100_valid", coin_valid, 0);
        chk("rej100_busy2", busy, 0);
        chk("rej100_count", coin_count, 9);
        chk("rej100_rem", remaining, 0);

        // Accepted start clears err and pays one nickel
        run(7'd5, 1'b0, 1, -1);
        chk("c5_err", err, 0);
        chk("c5_ncoins", got.size(), 1);
        chk("c5_coin", got.size() > 0 ? got[0] : 4'hF, 4'b0010);
        chk("c5_count", coin_count, 1);

        // Top of the 7-bit range is also rejected
        start = 1'b1; amount = 7'd127;
        tick();
        start = 1'b0;
        chk("rej127_err", err, 1);
        chk("rej127_busy", busy, 0);

        // 30 cents, ack after 5 cycles of presentation
        run(7'd30, 1'b0, 5, -1);
        chk("c30_ncoins", got.size(), 2);
        chk("c30_coin0", got.size() > 0 ? got[0] : 4'hF, 4'b1000);
        chk("c30_coin1", got.size() > 1 ? got[1] : 4'hF, 4'b0010);
        chk("c30_hold0", holds.size() > 0 ? holds[0] : -1, 5);
        chk("c30_hold1", holds.size() > 1 ? holds[1] : -1, 5);
        chk("c30_gap", gaps.size() > 0 ? gaps[0] : -1, 3);
        chk("c30_dones", dones, 1);
        chk("c30_count", coin_count, 2);
        chk("c30_err", err, 0);

        // Zero amount: no coins, done in cycle N+2
        run(7'd0, 1'b1, 0, -1);
        chk("c0_ncoins", got.size(), 0);
        chk("c0_done_cyc", done_cyc, 2);
        chk("c0_dones", dones, 1);
        chk("c0_count", coin_count, 0);

        // Start with amount=10 while busy is ignored
        run(7'd30, 1'b1, 0, 3);
        chk("busy_ncoins", got.size(), 2);
        chk("busy_coin0", got.size() > 0 ? got[0] : 4'hF, 4'b1000);
        chk("busy_coin1", got.size() > 1 ? got[1] : 4'hF, 4'b0010);
        chk("busy_count", coin_count, 2);
        tick(); tick();
        chk("busy_after", busy, 0);

        // 50 cents, reset while the second quarter is on offer
        coin_ack = 1'b0;
        start = 1'b1; amount = 7'd50;
        tick();
        start = 1'b0;
        tick();
        chk("r50_valid1", coin_valid, 1);
        chk("r50_type1", coin_type, 4'b1000);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("r50_rem1", remaining, 25);
        chk("r50_count1", coin_count, 1);
        tick(); tick(); tick();
        chk("r50_valid2", coin_valid, 1);
        chk("r50_type2", coin_type, 4'b1000);
        reset = 1'b1; start = 1'b1; amount = 7'd20; coin_ack = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; coin_ack = 1'b0;
        chk_idle_reset("r50_rst");
        tick();
        chk("r50_idle_busy", busy, 0);
        chk("r50_idle_valid", coin_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
